// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg -- shared types for the UART transmit frame engine.
// Rev 1.0
`default_nettype none

package uart_tx_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP1  = 3'd4,
        TX_STOP2  = 3'd5
    } tx_state_e;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

    typedef enum logic [1:0] {
        SEL_STOP  = 2'd0,
        SEL_START = 2'd1,
        SEL_DATA  = 2'd2,
        SEL_PAR   = 2'd3
    } tx_sel_e;

    // Which source drives the line while in a given state (idle shares the stop level).
    function automatic tx_sel_e line_sel(input logic [2:0] st);
        case (st)
            TX_START:  return SEL_START;
            TX_DATA:   return SEL_DATA;
            TX_PARITY: return SEL_PAR;
            default:   return SEL_STOP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_frame_engine_if.sv
// uart_tx_frame_engine_if -- word handshake, frame config and line outputs.
// Rev 1.0
`default_nettype none

interface uart_tx_frame_engine_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  STOP2;
    logic [PRESC_W-1:0]    Prescale;
    logic                  Data_Ack;
    logic                  TX_OUT;
    logic                  busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
        input  Data_Ack, TX_OUT, busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2, Prescale,
        output Data_Ack, TX_OUT, busy
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer -- counts 0..P-1 per bit, P = max(Prescale,1); flags the last cycle.
// Rev 1.0
`default_nettype none

module uart_tx_bit_timer #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clear,
    input  logic [PRESC_W-1:0] Prescale,
    output logic               bit_end
);
    logic [PRESC_W-1:0] count;
    logic [PRESC_W-1:0] last;

    assign last    = (Prescale == '0) ? '0 : Prescale - PRESC_W'(1);
    assign bit_end = (count == last);

    always_ff @(posedge CLK) begin
        if (RST || clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + PRESC_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine -- start, LSB-first data, optional parity, 1/2 stop bits; back-to-back capable.
// Rev 1.0
`default_nettype none

module uart_tx_frame_engine
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_tx_frame_engine_if.slave bus
);
    localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    localparam logic [2:0] S_IDLE   = TX_IDLE;
    localparam logic [2:0] S_START  = TX_START;
    localparam logic [2:0] S_DATA   = TX_DATA;
    localparam logic [2:0] S_PARITY = TX_PARITY;
    localparam logic [2:0] S_STOP1  = TX_STOP1;
    localparam logic [2:0] S_STOP2  = TX_STOP2;

    logic [2:0]            state, state_nxt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [PRESC_W-1:0]    presc_q, presc_nxt;
    logic                  par_en_q, par_en_nxt;
    logic                  par_typ_q, par_typ_nxt;
    logic                  stop2_q, stop2_nxt;
    logic                  tx_q, tx_nxt;
    logic                  busy_q;
    logic                  bit_end, frame_end, accept, par_bit, timer_clear;
    tx_sel_e               sel;

    assign frame_end   = bit_end && ((state == S_STOP2) || (state == S_STOP1 && !stop2_q));
    assign accept      = !RST && bus.Data_Valid && ((state == S_IDLE) || frame_end);
    assign timer_clear = accept || (state == S_IDLE);

    uart_tx_bit_timer #(.PRESC_W(PRESC_W)) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (timer_clear),
        .Prescale (presc_q),
        .bit_end  (bit_end)
    );

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        data_nxt    = data_q;
        presc_nxt   = presc_q;
        par_en_nxt  = par_en_q;
        par_typ_nxt = par_typ_q;
        stop2_nxt   = stop2_q;

        if (bit_end) begin
            case (state)
                S_START:  begin state_nxt = S_DATA; idx_nxt = '0; end
                S_DATA: begin
                    if (idx == LAST_IDX) state_nxt = par_en_q ? S_PARITY : S_STOP1;
                    else                 idx_nxt   = idx + IDX_W'(1);
                end
                S_PARITY: state_nxt = S_STOP1;
                S_STOP1:  state_nxt = stop2_q ? S_STOP2 : S_IDLE;
                S_STOP2:  state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end

        // A new word may be taken in idle or in the final stop cycle, giving zero idle gap.
        if (accept) begin
            state_nxt   = S_START;
            idx_nxt     = '0;
            data_nxt    = bus.P_DATA;
            presc_nxt   = bus.Prescale;
            par_en_nxt  = bus.PAR_EN;
            par_typ_nxt = bus.PAR_TYP;
            stop2_nxt   = bus.STOP2;
        end

        par_bit = (^data_nxt) ^ (par_typ_nxt == PAR_ODD);
        sel     = line_sel(state_nxt);
        case (sel)
            SEL_START: tx_nxt = 1'b0;
            SEL_DATA:  tx_nxt = data_nxt[idx_nxt];
            SEL_PAR:   tx_nxt = par_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            idx       <= '0;
            data_q    <= '0;
            presc_q   <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            data_q    <= data_nxt;
            presc_q   <= presc_nxt;
            par_en_q  <= par_en_nxt;
            par_typ_q <= par_typ_nxt;
            stop2_q   <= stop2_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= (state_nxt != S_IDLE);
        end
    end

    assign bus.Data_Ack = accept;
    assign bus.TX_OUT   = tx_q;
    assign bus.busy     = busy_q;
endmodule

`default_nettype wire
